// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and Memoria.
// master = requester/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_wr, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_wr, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port Memoria.
// CPU has fixed priority; the loader is forced through after STARVE_MAX back-to-back CPU grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    mem_port_arbiter_if.slave bus,
    output logic              busy_o,
    output logic              owner_o
);
    // state   | meaning
    // S_IDLE  | sample requests, arbitrate, latch winner
    // S_ISSUE | drive latched addr/data/wr to Memoria for one cycle
    // S_WAIT  | read in flight; capture mem_rdata when wcnt reaches 0
    // S_ACK   | one-cycle ack to the owner; requests ignored
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                owner_q;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [1:0]          wcnt_q;
    logic                busy_q;
    logic                cpu_ack_q, ld_ack_q;
    logic [DATA_W-1:0]   cpu_rdata_q, ld_rdata_q;
    logic                ld_win;

    // Only reaching the else-branch means the CPU won while the loader waited below the limit.
    always_comb begin
        ld_win   = bus.ld_req && ((starve_q == STARVE_W'(STARVE_MAX)) || !bus.cpu_req);
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (!bus.ld_req || ld_win) starve_d = '0;
            else                       starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            starve_q  <= starve_d;
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_req || bus.ld_req) begin
                        owner_q <= ld_win;
                        addr_q  <= ld_win ? bus.ld_addr  : bus.cpu_addr;
                        wr_q    <= ld_win ? bus.ld_wr    : bus.cpu_wr;
                        wdata_q <= ld_win ? bus.ld_wdata : bus.cpu_wdata;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wr_q) begin
                        cpu_ack_q <= !owner_q;
                        ld_ack_q  <= owner_q;
                        state_q   <= S_ACK;
                    end else begin
                        wcnt_q  <= 2'(READ_LAT - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 2'd0) begin
                        if (owner_q) ld_rdata_q  <= bus.mem_rdata;
                        else         cpu_rdata_q <= bus.mem_rdata;
                        cpu_ack_q <= !owner_q;
                        ld_ack_q  <= owner_q;
                        state_q   <= S_ACK;
                    end else begin
                        wcnt_q <= wcnt_q - 2'd1;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // mem_wr decodes the current state so a write in ISSUE commits even if reset is low that cycle.
    assign bus.mem_wr    = (state_q == S_ISSUE) && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ld_rdata  = ld_rdata_q;
    assign busy_o        = busy_q;
    assign owner_o       = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one READ_LAT=1 and one READ_LAT=3 instance, each with its own Memoria
// model, checked per cycle against a transaction-level model of arbitration, latency and memory.
module tb_mem_port_arbiter;
    localparam int SMAX = 4;

    logic clk;
    logic rst_n;
    logic busy_a, owner_a, busy_b, owner_b;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .STARVE_MAX(SMAX)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .bus(ia), .busy_o(busy_a), .owner_o(owner_a));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .STARVE_MAX(SMAX)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .bus(ib), .busy_o(busy_b), .owner_o(owner_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
    endfunction

    // Memoria models: A has 1-cycle read latency, B has 3.
    logic [31:0] mem_hw_a [256];
    logic [31:0] mem_hw_b [256];
    logic [31:0] pb1, pb2;
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_hw_a[i] = init_word(i);
            mem_hw_b[i] = init_word(i);
        end
        forever begin
            @(posedge clk);
            ia.mem_rdata <= mem_hw_a[ia.mem_addr[7:0]];
            pb1          <= mem_hw_b[ib.mem_addr[7:0]];
            pb2          <= pb1;
            ib.mem_rdata <= pb2;
            if (ia.mem_wr) mem_hw_a[ia.mem_addr[7:0]] = ia.mem_wdata;
            if (ib.mem_wr) mem_hw_b[ib.mem_addr[7:0]] = ib.mem_wdata;
        end
    end

    typedef struct packed {
        logic        busy;
        logic        owner;
        logic        cpu_ack;
        logic        ld_ack;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] cpu_rdata;
        logic [31:0] ld_rdata;
    } obs_t;

    int n_vec;
    int n_err;

    // reference model state, indexed by instance (0 = A, 1 = B)
    logic [31:0] mm [2][256];
    int          starve [2];
    logic [31:0] rd_cpu [2];
    logic [31:0] rd_ld [2];

    function automatic obs_t peek(int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = busy_a; o.owner = owner_a; o.cpu_ack = ia.cpu_ack; o.ld_ack = ia.ld_ack;
            o.mem_wr = ia.mem_wr; o.mem_addr = ia.mem_addr; o.mem_wdata = ia.mem_wdata;
            o.cpu_rdata = ia.cpu_rdata; o.ld_rdata = ia.ld_rdata;
        end else begin
            o.busy = busy_b; o.owner = owner_b; o.cpu_ack = ib.cpu_ack; o.ld_ack = ib.ld_ack;
            o.mem_wr = ib.mem_wr; o.mem_addr = ib.mem_addr; o.mem_wdata = ib.mem_wdata;
            o.cpu_rdata = ib.cpu_rdata; o.ld_rdata = ib.ld_rdata;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input bit cr, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cd, input bit lr, input bit lw,
                         input logic [31:0] la, input logic [31:0] ld);
        if (sel == 0) begin
            ia.cpu_req = cr; ia.cpu_wr = cw; ia.cpu_addr = ca; ia.cpu_wdata = cd;
            ia.ld_req  = lr; ia.ld_wr  = lw; ia.ld_addr  = la; ia.ld_wdata  = ld;
        end else begin
            ib.cpu_req = cr; ib.cpu_wr = cw; ib.cpu_addr = ca; ib.cpu_wdata = cd;
            ib.ld_req  = lr; ib.ld_wr  = lw; ib.ld_addr  = la; ib.ld_wdata  = ld;
        end
    endtask

    task automatic check_reset(input int sel);
        obs_t  o;
        string p;
        p = (sel == 0) ? "A" : "B";
        o = peek(sel);
        chk1({p, ".rst.busy"},    o.busy,    1'b0);
        chk1({p, ".rst.owner"},   o.owner,   1'b0);
        chk1({p, ".rst.cpu_ack"}, o.cpu_ack, 1'b0);
        chk1({p, ".rst.ld_ack"},  o.ld_ack,  1'b0);
        chk1({p, ".rst.mem_wr"},  o.mem_wr,  1'b0);
        chk({p, ".rst.mem_addr"},  o.mem_addr,  32'h0);
        chk({p, ".rst.mem_wdata"}, o.mem_wdata, 32'h0);
        chk({p, ".rst.cpu_rdata"}, o.cpu_rdata, 32'h0);
        chk({p, ".rst.ld_rdata"},  o.ld_rdata,  32'h0);
    endtask

    // Call at the falling edge inside an IDLE cycle; returns at the falling edge of the next IDLE cycle.
    task automatic txn(input int sel, input bit cr, input bit cw, input logic [31:0] ca,
                       input logic [31:0] cd, input bit lr, input bit lw,
                       input logic [31:0] la, input logic [31:0] ld, input bit scramble);
        int          win, lat, ackc;
        bit          w;
        logic [31:0] a, d;
        obs_t        o;
        string       p;
        p   = (sel == 0) ? "A" : "B";
        lat = (sel == 0) ? 1 : 3;
        starve[1-sel] = 0;   // the other instance idles with ld_req low
        drive(sel, cr, cw, ca, cd, lr, lw, la, ld);

        if (lr && starve[sel] == SMAX) win = 1;
        else if (cr)                   win = 0;
        else if (lr)                   win = 1;
        else                           win = -1;
        if (win == 0 && lr) starve[sel] = (starve[sel] < SMAX) ? starve[sel] + 1 : SMAX;
        else                starve[sel] = 0;

        @(posedge clk);
        if (win < 0) begin
            @(negedge clk);
            o = peek(sel);
            chk1({p, ".idle.busy"},    o.busy,    1'b0);
            chk1({p, ".idle.cpu_ack"}, o.cpu_ack, 1'b0);
            chk1({p, ".idle.ld_ack"},  o.ld_ack,  1'b0);
            chk1({p, ".idle.mem_wr"},  o.mem_wr,  1'b0);
            return;
        end

        a    = (win == 1) ? la : ca;
        d    = (win == 1) ? ld : cd;
        w    = (win == 1) ? lw : cw;
        ackc = w ? 2 : 2 + lat;

        for (int k = 1; k <= ackc; k++) begin
            @(negedge clk);
            o = peek(sel);
            if (k == ackc) begin
                if (w) mm[sel][a[7:0]] = d;
                else if (win == 1) rd_ld[sel] = mm[sel][a[7:0]];
                else rd_cpu[sel] = mm[sel][a[7:0]];
            end
            chk1($sformatf("%s.c%0d.busy", p, k),    o.busy,    1'b1);
            chk1($sformatf("%s.c%0d.owner", p, k),   o.owner,   win[0]);
            chk1($sformatf("%s.c%0d.cpu_ack", p, k), o.cpu_ack, (k == ackc) && (win == 0));
            chk1($sformatf("%s.c%0d.ld_ack", p, k),  o.ld_ack,  (k == ackc) && (win == 1));
            chk1($sformatf("%s.c%0d.mem_wr", p, k),  o.mem_wr,  (k == 1) && w);
            if (k < ackc) chk($sformatf("%s.c%0d.mem_addr", p, k), o.mem_addr, a);
            if (k == 1 && w) chk($sformatf("%s.c1.mem_wdata", p), o.mem_wdata, d);
            chk($sformatf("%s.c%0d.cpu_rdata", p, k), o.cpu_rdata, rd_cpu[sel]);
            chk($sformatf("%s.c%0d.ld_rdata", p, k),  o.ld_rdata,  rd_ld[sel]);
            if (scramble)
                drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom());
        end
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        obs_t o;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) mm[s][i] = init_word(i);
            starve[s] = 0;
            rd_cpu[s] = 32'h0;
            rd_ld[s]  = 32'h0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // CPU write then read-back on the READ_LAT=1 instance
        txn(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // both requesting writes continuously: CPU x4, loader, CPU, ...
        for (int i = 0; i < 11; i++)
            txn(0, 1'b1, 1'b1, 32'h40 + 32'(i), 32'h1000 + 32'(i), 1'b1, 1'b1, 32'h80 + 32'(i),
                32'h2000 + 32'(i), 1'b0);

        // loader read while the CPU side wiggles its inputs
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);

        // reset during the WAIT of a loader read
        starve[1] = 0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
        starve[0] = 0;
        @(posedge clk);
        @(negedge clk);
        o = peek(0);
        chk1("A.rstwait.issue.owner", o.owner, 1'b1);
        chk("A.rstwait.issue.mem_addr", o.mem_addr, 32'h24);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        o = peek(0);
        chk1("A.rstwait.wait.ld_ack", o.ld_ack, 1'b0);
        chk1("A.rstwait.wait.mem_wr", o.mem_wr, 1'b0);
        chk("A.rstwait.wait.mem_addr", o.mem_addr, 32'h24);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset(0);
        check_reset(1);
        for (int s = 0; s < 2; s++) begin
            starve[s] = 0;
            rd_cpu[s] = 32'h0;
            rd_ld[s]  = 32'h0;
        end
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // READ_LAT=3 instance: write, read-back, loader read
        txn(1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        txn(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);

        // randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = (i < 40) ? 0 : 1;
            txn(sel, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
